// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU command path: operation codes, register
// offsets inside the FPU window, default window base and sequencer states.
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_MUL  = 2'd3
    } fpu_op_t;

    localparam logic [5:0]  OFF_A            = 6'h00;
    localparam logic [5:0]  OFF_B            = 6'h04;
    localparam logic [5:0]  OFF_CMD          = 6'h08;
    localparam logic [12:0] FPU_BASE_DEFAULT = 13'h0600;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_A   = 3'd1,
        ST_WR_B   = 3'd2,
        ST_WR_CMD = 3'd3,
        ST_WAIT   = 3'd4,
        ST_RESP   = 3'd5
    } seq_state_t;

    // Register address inside the window; base has its low six bits clear,
    // so the add never carries into the base field.
    function automatic logic [12:0] reg_addr(input logic [12:0] base, input logic [5:0] off);
        return base + {7'b0, off};
    endfunction

endpackage

// File: rtl/fpu_cmd_sequencer.sv
// Upstream driver for the memory-mapped FPU register block. Takes one
// (op, A, B) request, writes A, B and the command into the FPU window,
// waits READ_WAIT cycles, captures the FPU result and returns it.
//
// Handshake semantics (both interfaces): a transfer happens on a rising clk
// edge where valid && ready are both high. The source holds valid and its
// payload stable until that edge; ready never depends combinationally on
// valid. Here req_ready = (state == IDLE) and rsp_valid = (state == RESP).
module fpu_cmd_sequencer
    import fpu_pkg::*;
#(
    parameter logic [12:0] BASE_ADDR = FPU_BASE_DEFAULT,
    parameter int          READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        fpu_cs,
    output logic [12:0] fpu_addr,
    output logic [31:0] fpu_wdata,
    input  logic [31:0] fpu_rdata,
    output logic        busy,
    output seq_state_t  dbg_state
);

    localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(READ_WAIT - 1);

    seq_state_t    state, state_next;
    fpu_op_t       op_q;
    logic [31:0]   a_q, b_q;
    logic [CW-1:0] cnt;

    logic          req_fire;
    logic          req_is_none;
    logic          cs_next;
    logic [12:0]   addr_next;
    logic [31:0]   wdata_next;

    assign req_ready   = (state == ST_IDLE);
    assign rsp_valid   = (state == ST_RESP);
    assign busy        = (state != ST_IDLE);
    assign dbg_state   = state;
    assign req_fire    = req_valid && req_ready;
    assign req_is_none = (req_op == OP_NONE);

    // Next-state decode plus the bus values for the cycle after this edge;
    // bus outputs are then registered so nothing reaches the FPU pins
    // combinationally from req_*.
    always_comb begin
        state_next = state;
        cs_next    = 1'b0;
        addr_next  = 13'h0;
        wdata_next = 32'h0;
        case (state)
            ST_IDLE: begin
                if (req_fire) begin
                    if (req_is_none) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WR_A;
                        cs_next    = 1'b1;
                        addr_next  = reg_addr(BASE_ADDR, OFF_A);
                        wdata_next = req_a;
                    end
                end
            end
            ST_WR_A: begin
                state_next = ST_WR_B;
                cs_next    = 1'b1;
                addr_next  = reg_addr(BASE_ADDR, OFF_B);
                wdata_next = b_q;
            end
            ST_WR_B: begin
                state_next = ST_WR_CMD;
                cs_next    = 1'b1;
                addr_next  = reg_addr(BASE_ADDR, OFF_CMD);
                wdata_next = {30'b0, op_q};
            end
            ST_WR_CMD: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch: captured once at the handshake, ignored afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= OP_NONE;
            a_q  <= 32'h0;
            b_q  <= 32'h0;
        end else if (req_fire) begin
            op_q <= fpu_op_t'(req_op);
            a_q  <= req_a;
            b_q  <= req_b;
        end
    end

    // Registered FPU bus; address and data are forced to zero outside a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpu_cs    <= 1'b0;
            fpu_addr  <= 13'h0;
            fpu_wdata <= 32'h0;
        end else begin
            fpu_cs    <= cs_next;
            fpu_addr  <= addr_next;
            fpu_wdata <= wdata_next;
        end
    end

    // Result wait counter: loaded as WAIT is entered, counts down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == ST_WR_CMD) begin
            cnt <= CNT_LOAD;
        end else if (state == ST_WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Response payload: FPU result captured on the last WAIT cycle, or the
    // error response for an op-0 request; rsp_data holds after the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_data <= 32'h0;
            rsp_err  <= 1'b0;
        end else begin
            if (req_fire && req_is_none) begin
                rsp_data <= 32'h0;
                rsp_err  <= 1'b1;
            end else if (state == ST_WAIT && cnt == '0) begin
                rsp_data <= fpu_rdata;
                rsp_err  <= 1'b0;
            end else if (state == ST_RESP && rsp_ready) begin
                rsp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Bench for fpu_cmd_sequencer: a READ_WAIT=1 instance and a READ_WAIT=3
// instance, each driving a small behavioural FPU register block.
module tb_fpu_cmd_sequencer;
    import fpu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT (READ_WAIT = 1) ----------------
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b, rsp_data, fpu_wdata, fpu_rdata;
    logic        fpu_cs, busy;
    logic [12:0] fpu_addr;
    seq_state_t  dbg_state;

    fpu_cmd_sequencer #(.BASE_ADDR(13'h0600), .READ_WAIT(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fpu_cs(fpu_cs), .fpu_addr(fpu_addr), .fpu_wdata(fpu_wdata), .fpu_rdata(fpu_rdata),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- DUT (READ_WAIT = 3) ----------------
    logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3;
    logic [1:0]  req_op3;
    logic [31:0] req_a3, req_b3, rsp_data3, fpu_wdata3, fpu_rdata3;
    logic        fpu_cs3, busy3;
    logic [12:0] fpu_addr3;
    seq_state_t  dbg_state3;

    fpu_cmd_sequencer #(.BASE_ADDR(13'h0600), .READ_WAIT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
        .req_a(req_a3), .req_b(req_b3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_err(rsp_err3),
        .fpu_cs(fpu_cs3), .fpu_addr(fpu_addr3), .fpu_wdata(fpu_wdata3), .fpu_rdata(fpu_rdata3),
        .busy(busy3), .dbg_state(dbg_state3)
    );

    // ---------------- FPU register block models ----------------
    logic [31:0] ra = 32'h0, rb = 32'h0, res = 32'h0;
    logic [31:0] ra3 = 32'h0, rb3 = 32'h0, res3 = 32'h0;
    assign fpu_rdata  = res;
    assign fpu_rdata3 = res3;

    always @(posedge clk) begin
        if (fpu_cs) begin
            case (fpu_addr)
                13'h0600: ra <= fpu_wdata;
                13'h0604: rb <= fpu_wdata;
                13'h0608: begin
                    case (fpu_wdata[1:0])
                        2'd1:    res <= ra + rb;
                        2'd2:    res <= ra - rb;
                        2'd3:    res <= ra * rb;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (fpu_cs3) begin
            case (fpu_addr3)
                13'h0600: ra3 <= fpu_wdata3;
                13'h0604: rb3 <= fpu_wdata3;
                13'h0608: begin
                    case (fpu_wdata3[1:0])
                        2'd1:    res3 <= ra3 + rb3;
                        2'd2:    res3 <= ra3 - rb3;
                        2'd3:    res3 <= ra3 * rb3;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected FPU bus writes: {addr, wdata}.
    logic [44:0] exp_q[$];
    int          cs3_cnt = 0;

    always @(negedge clk) begin
        if (fpu_cs) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bus_write", 64'({fpu_addr, fpu_wdata}), 64'(0));
                if (fpu_addr == 13'h0 && fpu_wdata == 32'h0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bus_write: cs=1 expected cs=0 at %0t", $time);
                end
            end else begin
                check("bus_write", 64'({fpu_addr, fpu_wdata}), 64'(exp_q.pop_front()));
            end
        end else begin
            check("bus_idle_zero", 64'({fpu_addr, fpu_wdata}), 64'(0));
        end
        if (fpu_cs3) cs3_cnt++;
    end

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[6];

    // One request/response transaction on the READ_WAIT=1 instance.
    task automatic run_op(input vec_t v);
        int n;
        int lat;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_before", 64'(req_ready), 64'(1));
        if (v.op != 2'd0) begin
            exp_q.push_back({13'h0600, v.a});
            exp_q.push_back({13'h0604, v.b});
            exp_q.push_back({13'h0608, 30'b0, v.op});
        end
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom_range(0, 3));
        req_a     = $urandom;
        req_b     = $urandom;
        check("req_ready_after_hs", 64'(req_ready), 64'(0));
        check("busy_after_hs", 64'(busy), 64'(1));
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_latency", 64'(lat), 64'(v.lat));
        check("rsp_data", 64'(rsp_data), 64'(v.data));
        check("rsp_err", 64'(rsp_err), 64'(v.err));
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            check("hold_rsp_valid", 64'(rsp_valid), 64'(1));
            check("hold_rsp_data", 64'(rsp_data), 64'(v.data));
            check("hold_req_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_rsp_hs", 64'(rsp_valid), 64'(0));
        check("req_ready_after_rsp_hs", 64'(req_ready), 64'(1));
        check("rsp_err_cleared", 64'(rsp_err), 64'(0));
        check("rsp_data_kept", 64'(rsp_data), 64'(v.data));
        check("bus_writes_done", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int lat;
        vecs[0] = '{2'd1, 32'd5,          32'd7,          32'd12,         1'b0, 5, 0};
        vecs[1] = '{2'd2, 32'd10,         32'd3,          32'd7,          1'b0, 5, 0};
        vecs[2] = '{2'd3, 32'h0001_0000,  32'h0001_0000,  32'h0,          1'b0, 5, 0};
        vecs[3] = '{2'd1, 32'd5,          32'd7,          32'd12,         1'b0, 5, 10};
        vecs[4] = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          1'b1, 1, 0};
        vecs[5] = '{2'd2, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 5, 0};

        reset      = 1'b1;
        req_valid  = 1'b0; req_op  = 2'd0; req_a  = 32'h0; req_b  = 32'h0; rsp_ready  = 1'b0;
        req_valid3 = 1'b0; req_op3 = 2'd0; req_a3 = 32'h0; req_b3 = 32'h0; rsp_ready3 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check("reset_req_ready", 64'(req_ready), 64'(1));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_data", 64'(rsp_data), 64'(0));
        check("reset_rsp_err", 64'(rsp_err), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_fpu_cs", 64'(fpu_cs), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));

        // Table-driven transactions
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i]);
        end

        // Reset during WR_B: bus drops at once, no response appears
        exp_q.push_back({13'h0600, 32'd9});
        exp_q.push_back({13'h0604, 32'd9});
        exp_q.push_back({13'h0608, 32'd1});
        req_valid = 1'b1; req_op = 2'd1; req_a = 32'd9; req_b = 32'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("midop_state_wr_b", 64'(dbg_state), 64'(ST_WR_B));
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("midop_fpu_cs", 64'(fpu_cs), 64'(0));
        check("midop_fpu_addr", 64'(fpu_addr), 64'(0));
        check("midop_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midop_busy", 64'(busy), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_req_ready", 64'(req_ready), 64'(1));
        check("post_reset_rsp_valid", 64'(rsp_valid), 64'(0));
        run_op('{2'd1, 32'd2, 32'd2, 32'd4, 1'b0, 5, 0});

        // READ_WAIT=3 instance: 1+1, request inputs scrambled after handshake
        cs3_cnt    = 0;
        rsp_ready3 = 1'b1;
        req_valid3 = 1'b1; req_op3 = 2'd1; req_a3 = 32'd1; req_b3 = 32'd1;
        @(posedge clk); #1;
        req_valid3 = 1'b0; req_op3 = 2'd3; req_a3 = 32'd100; req_b3 = 32'd200;
        check("rw3_req_ready_after_hs", 64'(req_ready3), 64'(0));
        lat = 1;
        while (!rsp_valid3 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rw3_rsp_latency", 64'(lat), 64'(7));
        check("rw3_rsp_data", 64'(rsp_data3), 64'(2));
        check("rw3_rsp_err", 64'(rsp_err3), 64'(0));
        check("rw3_cs_pulses", 64'(cs3_cnt), 64'(3));
        @(posedge clk); #1;
        check("rw3_rsp_valid_after", 64'(rsp_valid3), 64'(0));
        check("rw3_req_ready_after", 64'(req_ready3), 64'(1));
        rsp_ready3 = 1'b0;

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
